apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
Two-requester APB master that shares a single APB slave bus (a register bank) between two internal clients.
- Each client issues single read/write requests over a simple req/done interface.
- The block arbitrates round-robin, runs the APB SETUP/ACCESS sequence and honours pready wait states.
- It aborts a transfer with an error if pready never arrives.

Parameters:
AW, 5, APB address width (byte address; ls 2 bits passed through unchanged)
DW, 32, data width
TIMEOUT, 16, max ACCESS cycles waiting for pready before abort; 0 = no timeout
TW, 8, width of timeout counter (must hold TIMEOUT)

Ports:
pclk  input  1  clock
reset  input  1  asynchronous active-high reset
m0_req  input  1  client 0 request, held high until m0_done
m0_write  input  1  client 0: 1=write, 0=read
m0_addr  input  AW  client 0 address
m0_wdata  input  DW  client 0 write data
m0_done  output  1  one-cycle completion pulse to client 0
m0_rdata  output  DW  read data for client 0, valid with m0_done
m0_err  output  1  error flag, valid with m0_done
m1_req / m1_write / m1_addr / m1_wdata  input  1/1/AW/DW  client 1, same as client 0
m1_done / m1_rdata / m1_err  output  1/DW/1  client 1, same as client 0
paddr  output  AW  APB address
pwrite  output  1  APB write strobe
psel  output  1  APB select
penable  output  1  APB enable
pwdata  output  DW  APB write data
prdata  input  DW  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error
busy  output  1  high while state != IDLE

Behaviour:
- Reset values: all outputs 0; priority pointer = client 0; state IDLE; timeout counter 0.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the client named by the priority pointer.
  - On grant: latch owner, addr, write and wdata into paddr/pwrite/pwdata; psel<=1, penable<=0; go to SETUP.
  - If no req is high, stay in IDLE; psel=penable=0. paddr/pwdata hold their last values.
- SETUP: penable<=1, clear timeout counter, go to ACCESS. Always exactly one cycle.
- ACCESS, normal completion:
  - If pready=1 this cycle: psel<=0, penable<=0; pulse owner done for one cycle.
  - Owner rdata<=prdata on reads; owner rdata is unchanged on writes.
  - Owner err<=pslverr.
  - Flip the priority pointer to the non-owner; go to IDLE.
- ACCESS, waiting: if pready=0, increment the timeout counter.
- ACCESS, timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT-1 with pready still 0, abort exactly as normal completion except err=1 and rdata unchanged.
- Priority: the pointer updates only on completion/abort, never on an idle cycle.
- Throughput: minimum 3 cycles per transfer (IDLE, SETUP, ACCESS). Back-to-back transfers always pass through IDLE, so psel drops for ≥1 cycle between transfers.
- Latency: grant registered in the cycle after req is seen in IDLE. done asserted in the cycle after pready is sampled high.
- done pulses:
  - m0_done and m1_done are never high together.
  - The non-owner's done/rdata/err are untouched by the other client's transfer.
  - err holds its value until that client's next done.
- Client drops req mid-transfer: ignored; the transfer runs to completion and done still pulses.
- Client keeps req high in the cycle done is pulsed: the client must drop req in that cycle. A req still high in the following IDLE is treated as a new request.
- pslverr: sampled only when pready=1 in ACCESS.
- Reset asserted mid-transfer: immediate return to IDLE; psel/penable low asynchronously; no done is issued.

Test Plan:
- Single write: m0 req write addr 0x10 data 0xDEADBEEF, pready tied 1 -> psel high 2 cycles, penable high 1 cycle with paddr=0x10, pwdata=0xDEADBEEF, pwrite=1; m0_done pulses 3 cycles after req, m0_err=0.
- Read with wait state: m1 read addr 0x1C, slave holds pready=0 for 1 ACCESS cycle then returns prdata=0x00216948 -> m1_rdata=0x00216948 with m1_done; penable high 2 cycles.
- Contention: m0 and m1 both request continuously, 4 transfers -> grant order m0, m1, m0, m1; psel low ≥1 cycle between transfers; never both done high.
- Timeout: TIMEOUT=16, pready held 0 -> abort after 16 ACCESS cycles; m0_done with m0_err=1; m0_rdata keeps its previous value; busy then drops.
- Slave error: pslverr=1 with pready=1 on a write -> m1_err=1; the next m1 transfer with pslverr=0 clears m1_err.
- Reset mid-ACCESS: assert reset while penable=1 -> psel/penable/busy go 0 without a clock edge; no done; after release the priority pointer is client 0.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter that lets two internal clients share one
// APB slave. The block runs SETUP/ACCESS, waits for pready and aborts a stalled
// transfer after TIMEOUT ACCESS cycles. Every output comes from a flop.
module apb_req_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic [AW-1:0] paddr,
  output logic          pwrite,
  output logic          psel,
  output logic          penable,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic          req;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } creq_t;

  // Last counter value before abort; only meaningful when TIMEOUT != 0.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  creq_t  [1:0]         cr;
  state_t               state, state_n;
  logic                 owner, owner_n;
  logic                 ptr, ptr_n;
  logic [TW-1:0]        cnt, cnt_n;
  logic [AW-1:0]        paddr_n;
  logic                 pwrite_n, psel_n, penable_n, busy_n;
  logic [DW-1:0]        pwdata_n;
  logic [1:0]           done_q, done_n;
  logic [1:0]           err_q, err_n;
  logic [1:0][DW-1:0]   rdata_q, rdata_n;
  logic                 sel;
  logic                 fin, fin_err;

  assign cr[0] = '{req: m0_req, write: m0_write, addr: m0_addr, wdata: m0_wdata};
  assign cr[1] = '{req: m1_req, write: m1_write, addr: m1_addr, wdata: m1_wdata};

  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];

  // Next-state and next-output decode; everything defaults to hold except done.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    ptr_n     = ptr;
    cnt_n     = cnt;
    paddr_n   = paddr;
    pwrite_n  = pwrite;
    pwdata_n  = pwdata;
    psel_n    = psel;
    penable_n = penable;
    done_n    = 2'b00;
    err_n     = err_q;
    rdata_n   = rdata_q;
    sel       = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    unique case (state)
      IDLE: begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
        if (cr[0].req || cr[1].req) begin
          // Contention goes to the pointer; otherwise the lone requester wins.
          sel       = (cr[0].req && cr[1].req) ? ptr : cr[1].req;
          owner_n   = sel;
          paddr_n   = cr[sel].addr;
          pwrite_n  = cr[sel].write;
          pwdata_n  = cr[sel].wdata;
          psel_n    = 1'b1;
          state_n   = SETUP;
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        cnt_n     = '0;
        state_n   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          fin     = 1'b1;
          fin_err = pslverr;
          if (!pwrite) rdata_n[owner] = prdata;
        end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        if (fin) begin
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          done_n[owner] = 1'b1;
          err_n[owner]  = fin_err;
          ptr_n         = ~owner;
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs; reset forces the bus idle immediately.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      cnt     <= '0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      busy    <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      paddr   <= paddr_n;
      pwrite  <= pwrite_n;
      pwdata  <= pwdata_n;
      psel    <= psel_n;
      penable <= penable_n;
      busy    <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
      rdata_q <= rdata_n;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed bench for the two-client APB arbiter. A small
// slave responder inside the transfer task drives pready/prdata/pslverr.
module tb_apb_req_arbiter;

  logic        pclk = 1'b0;
  logic        reset;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [4:0]  m0_addr, m1_addr, paddr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, pwdata, prdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic        pwrite, psel, penable, pready, pslverr, busy;

  int checks = 0;
  int errors = 0;

  int          n_psel, n_pen, lat, other;
  logic [4:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_write;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.AW(5), .DW(32), .TIMEOUT(16), .TW(8)) dut (
    .pclk(pclk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transfer from client m. The slave inserts `waits` wait states once
  // penable is seen, then answers with rdat/serr. Starts and ends on a negedge.
  task automatic xfer(input int m, input bit wr, input logic [4:0] a, input logic [31:0] d,
                      input int waits, input logic [31:0] rdat, input bit serr);
    int wc;
    bit got;
    n_psel = 0; n_pen = 0; lat = 0; other = 0; wc = 0; got = 0;
    if (m == 0) begin m0_req = 1; m0_write = wr; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1; m1_write = wr; m1_addr = a; m1_wdata = d; end
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge pclk);
      if (psel) n_psel++;
      if (penable) begin
        n_pen++;
        if (n_pen == 1) begin cap_addr = paddr; cap_wdata = pwdata; cap_write = pwrite; end
      end
      if (m == 0 ? m1_done : m0_done) other++;
      if (m == 0 ? m0_done : m1_done) begin
        got = 1; lat = c;
        if (m == 0) m0_req = 0; else m1_req = 0;
      end
      pready = 0; pslverr = 0;
      if (!got && psel && penable) begin
        if (wc < waits) wc++;
        else begin pready = 1; prdata = rdat; pslverr = serr; end
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int ord[4];
  int nd, both, lowrun, mingap, seen;

  initial begin
    reset = 1; m0_req = 0; m1_req = 0; m0_write = 0; m1_write = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    prdata = 0; pready = 0; pslverr = 0;
    repeat (2) @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {m0_done, m1_done}, 0);
    chk("rst_err", {m0_err, m1_err}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata0", m0_rdata, 0);
    reset = 0;
    @(negedge pclk);

    // Single write from m0, slave ready immediately.
    xfer(0, 1, 5'h10, 32'hDEADBEEF, 0, 32'h0, 0);
    chk("wr_psel_cyc", n_psel, 2);
    chk("wr_pen_cyc", n_pen, 1);
    chk("wr_lat", lat, 3);
    chk("wr_paddr", cap_addr, 32'h10);
    chk("wr_pwdata", cap_wdata, 32'hDEADBEEF);
    chk("wr_pwrite", cap_write, 1);
    chk("wr_err", m0_err, 0);
    chk("wr_busy_at_done", busy, 0);
    chk("wr_other_done", other, 0);
    @(negedge pclk);
    chk("wr_done_pulse", m0_done, 0);

    // m1 read with one wait state.
    xfer(1, 0, 5'h1C, 32'h0, 1, 32'h00216948, 0);
    chk("rd_rdata", m1_rdata, 32'h00216948);
    chk("rd_pen_cyc", n_pen, 2);
    chk("rd_lat", lat, 4);
    chk("rd_err", m1_err, 0);
    chk("rd_paddr", cap_addr, 32'h1C);
    chk("rd_m0_rdata_kept", m0_rdata, 0);
    chk("rd_other_done", other, 0);
    @(negedge pclk);

    // Contention: both clients hold req for four transfers.
    m0_req = 1; m0_write = 0; m0_addr = 5'h04;
    m1_req = 1; m1_write = 0; m1_addr = 5'h08;
    nd = 0; both = 0; lowrun = 0; mingap = 99; seen = 0;
    for (int c = 0; c < 200 && nd < 4; c++) begin
      @(negedge pclk);
      if (m0_done && m1_done) both++;
      if (m0_done || m1_done) begin ord[nd] = m1_done ? 1 : 0; nd++; end
      if (psel) begin
        if (seen && lowrun > 0 && lowrun < mingap) mingap = lowrun;
        lowrun = 0;
      end else if (nd > 0) begin
        seen = 1; lowrun++;
      end
      if (nd == 4) begin m0_req = 0; m1_req = 0; end
      pready = psel && penable && nd < 4;
      prdata = {27'h0, paddr};
      pslverr = 0;
    end
    pready = 0;
    chk("cont_count", nd, 4);
    chk("cont_ord0", ord[0], 0);
    chk("cont_ord1", ord[1], 1);
    chk("cont_ord2", ord[2], 0);
    chk("cont_ord3", ord[3], 1);
    chk("cont_both_done", both, 0);
    chk("cont_gap_ge1", (mingap >= 1 && mingap < 99), 1);
    chk("cont_rdata0", m0_rdata, 32'h04);
    chk("cont_rdata1", m1_rdata, 32'h08);
    @(negedge pclk);

    // Timeout: known read first, then a transfer the slave never answers.
    xfer(0, 0, 5'h0C, 32'h0, 0, 32'h12345678, 0);
    chk("to_pre_rdata", m0_rdata, 32'h12345678);
    @(negedge pclk);
    xfer(0, 0, 5'h0C, 32'h0, 1000, 32'hFFFFFFFF, 0);
    chk("to_pen_cyc", n_pen, 16);
    chk("to_lat", lat, 18);
    chk("to_err", m0_err, 1);
    chk("to_rdata_kept", m0_rdata, 32'h12345678);
    chk("to_busy", busy, 0);
    @(negedge pclk);

    // Slave error on an m1 write, then cleared by the next m1 transfer.
    xfer(1, 1, 5'h14, 32'hA5A5A5A5, 0, 32'h0, 1);
    chk("serr_set", m1_err, 1);
    repeat (3) @(negedge pclk);
    chk("serr_hold", m1_err, 1);
    chk("serr_m0_err_kept", m0_err, 1);
    xfer(1, 1, 5'h14, 32'h5A5A5A5A, 0, 32'h0, 0);
    chk("serr_clear", m1_err, 0);
    @(negedge pclk);

    // Reset mid-ACCESS. Leave the pointer at client 1 first.
    xfer(0, 1, 5'h00, 32'h1, 0, 32'h0, 0);
    @(negedge pclk);
    m1_req = 1; m1_write = 0; m1_addr = 5'h18;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge pclk);
      if (penable) seen = 1;
    end
    chk("rst_reached_access", seen, 1);
    #2 reset = 1;
    #1;
    chk("rst_async_psel", psel, 0);
    chk("rst_async_penable", penable, 0);
    chk("rst_async_busy", busy, 0);
    m1_req = 0;
    @(negedge pclk);
    reset = 0;
    both = 0;
    repeat (3) begin
      @(negedge pclk);
      if (m0_done || m1_done) both++;
    end
    chk("rst_no_done", both, 0);
    m0_req = 1; m0_write = 0; m0_addr = 5'h02;
    m1_req = 1; m1_write = 0; m1_addr = 5'h03;
    nd = -1;
    for (int c = 0; c < 20 && nd < 0; c++) begin
      @(negedge pclk);
      if (m0_done || m1_done) begin
        nd = m1_done ? 1 : 0;
        m0_req = 0; m1_req = 0;
      end
      pready = psel && penable && nd < 0;
      prdata = 32'h0; pslverr = 0;
    end
    pready = 0;
    chk("rst_ptr_m0", nd, 0);
    repeat (2) @(negedge pclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
